// File: rtl/job_sequencer.sv
// job_sequencer: runs one hashing job on a pool of hashing units.
// Holds the pool in reset for RESET_HOLD cycles, releases it, then waits for a
// qualifying hash (captured nonce and per-unit match flags) or for an abort.
// Optional feature: define JOB_SEQUENCER_EXHAUST_EN to compile in the round
// counter and the DONE_EMPTY exit taken when the nonce range is exhausted.
// All outputs come straight from flops.
module job_sequencer #(
    parameter int unsigned POOL_SIZE    = 2,
    parameter int unsigned RESET_HOLD   = 4,
    parameter int unsigned EXHAUST_LOG2 = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_start,
    input  logic                 job_abort,
    input  logic                 round_done_in,
    input  logic                 success_in,
    input  logic [31:0]          nonce_in,
    input  logic [POOL_SIZE-1:0] match_flags_in,
    input  logic                 result_ack,
    output logic                 core_reset_n,
    output logic                 ready,
    output logic                 busy,
    output logic                 exhausted,
    output logic [31:0]          result_nonce,
    output logic [POOL_SIZE-1:0] result_flags
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StFound,
        StDoneEmpty
    } state_e;

    state_e state_q, state_d;

    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic                 hold_done;
    logic                 round_limit;
    logic                 capture;

    logic [31:0]          result_nonce_q, result_nonce_d;
    logic [POOL_SIZE-1:0] result_flags_q, result_flags_d;

    logic core_reset_n_q, core_reset_n_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic exhausted_q, exhausted_d;

    // LOAD lasts exactly RESET_HOLD cycles: counter walks 0 .. RESET_HOLD-1.
    assign hold_done = (hold_cnt_q == 4'(RESET_HOLD - 1));

    // A success is taken only in RUN and only when no restart/abort overrides it.
    assign capture = (state_q == StRun) && success_in && !job_start && !job_abort;

`ifdef JOB_SEQUENCER_EXHAUST_EN
    localparam logic [EXHAUST_LOG2:0] RoundLimit = {1'b1, {EXHAUST_LOG2{1'b0}}};

    logic [EXHAUST_LOG2:0] round_cnt_q, round_cnt_d;
    logic [EXHAUST_LOG2:0] round_inc;

    assign round_inc = round_cnt_q + {{EXHAUST_LOG2{1'b0}}, 1'b1};

    // The round that brings the count to 2^EXHAUST_LOG2 is the exhausting one.
    assign round_limit = (state_q == StRun) && round_done_in && (round_inc == RoundLimit);

    // Round counter: cleared on every job (re)start, counts pool rounds in RUN.
    always_comb begin
        round_cnt_d = round_cnt_q;
        if (job_start) begin
            round_cnt_d = '0;
        end else if ((state_q == StRun) && round_done_in) begin
            round_cnt_d = round_inc;
        end
    end

    // Round counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_cnt_q <= '0;
        end else begin
            round_cnt_q <= round_cnt_d;
        end
    end
`else
    logic [EXHAUST_LOG2:0] unused_round;

    assign unused_round = {(EXHAUST_LOG2 + 1){round_done_in}};
    assign round_limit  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: restart beats abort, abort beats success, success beats exhaustion.
    always_comb begin
        state_d = state_q;
        if (job_start) begin
            state_d = StLoad;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StLoad: begin
                    if (job_abort) begin
                        state_d = StIdle;
                    end else if (hold_done) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (job_abort) begin
                        state_d = StIdle;
                    end else if (success_in) begin
                        state_d = StFound;
                    end else if (round_limit) begin
                        state_d = StDoneEmpty;
                    end
                end
                StFound, StDoneEmpty: begin
                    if (result_ack) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        core_reset_n_d = (state_d == StRun);
        busy_d         = (state_d == StLoad) || (state_d == StRun);
        ready_d        = (state_d == StFound) || (state_d == StDoneEmpty);
`ifdef JOB_SEQUENCER_EXHAUST_EN
        exhausted_d    = (state_d == StDoneEmpty);
`else
        exhausted_d    = 1'b0;
`endif
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset_n_q <= 1'b0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            exhausted_q    <= 1'b0;
        end else begin
            core_reset_n_q <= core_reset_n_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            exhausted_q    <= exhausted_d;
        end
    end

    // Hold counter: restarts on every job start, advances while in LOAD.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (job_start) begin
            hold_cnt_d = '0;
        end else if ((state_q == StLoad) && !hold_done) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Result capture: cleared when a job is (re)started, loaded on success in RUN.
    always_comb begin
        result_nonce_d = result_nonce_q;
        result_flags_d = result_flags_q;
        if (job_start) begin
            result_nonce_d = '0;
            result_flags_d = '0;
        end else if (capture) begin
            result_nonce_d = nonce_in;
            result_flags_d = match_flags_in;
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_nonce_q <= '0;
            result_flags_q <= '0;
        end else begin
            result_nonce_q <= result_nonce_d;
            result_flags_q <= result_flags_d;
        end
    end

    assign core_reset_n = core_reset_n_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign exhausted    = exhausted_q;
    assign result_nonce = result_nonce_q;
    assign result_flags = result_flags_q;

endmodule

// File: doc/job_sequencer.md
JOB_SEQUENCER -- requirements
Module: job_sequencer

Interface
REQ-001 SHALL have parameter POOL_SIZE, default 2, number of hashing units in the pool.
REQ-002 SHALL have parameter RESET_HOLD, default 4, cycles core_reset_n is held low before a job runs (legal range 1..15).
REQ-003 SHALL have parameter EXHAUST_LOG2, default 23, log2 of the hash rounds that exhaust one device's nonce range.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- job_start  in  1  one-cycle pulse: new job/device config latched, begin a job
- job_abort  in  1  one-cycle pulse: stop the current job
- round_done_in  in  1  pool strobe: one hash round completed by all units
- success_in  in  1  pool reports a qualifying hash
- nonce_in  in  32  pool nonce accompanying success_in
- match_flags_in  in  POOL_SIZE  per-unit match flags accompanying success_in
- result_ack  in  1  host has read the result
- core_reset_n  out  1  active-low reset to the hasher pool
- ready  out  1  result or exhaustion pending; drives open-drain READY
- busy  out  1  job loading or running
- exhausted  out  1  range exhausted without success
- result_nonce  out  32  captured nonce
- result_flags  out  POOL_SIZE  captured match flags

Function
REQ-005 SHALL implement states IDLE, LOAD, RUN, FOUND, DONE_EMPTY.
REQ-006 IDLE: core_reset_n=0, busy=0, ready=0; job_start -> LOAD.
REQ-007 LOAD: core_reset_n=0, busy=1; hold counter counts RESET_HOLD cycles, then -> RUN; the round counter is cleared on LOAD entry.
REQ-008 RUN: core_reset_n=1, busy=1; each round_done_in increments a round counter of width EXHAUST_LOG2+1.
REQ-009 RUN with success_in=1: on that edge, capture nonce_in into result_nonce and match_flags_in into result_flags, -> FOUND; core_reset_n=0 from the next cycle.
REQ-010 RUN with the round counter reaching 2^EXHAUST_LOG2 (counted round_done_in included): -> DONE_EMPTY.
REQ-011 Same-cycle success_in and exhaustion SHALL resolve to FOUND.
REQ-012 FOUND: ready=1, busy=0, core_reset_n=0; result_nonce and result_flags hold stable until the next LOAD entry.
REQ-013 DONE_EMPTY: ready=1, exhausted=1, busy=0, core_reset_n=0; result_nonce and result_flags unchanged.
REQ-014 result_ack in FOUND or DONE_EMPTY -> IDLE and clears ready and exhausted; result_ack in other states is ignored.
REQ-015 job_start in any state other than IDLE SHALL restart: -> LOAD, clearing ready, exhausted and the counters; the captured result is cleared to zero on LOAD entry.
REQ-016 job_abort in LOAD or RUN -> IDLE, with no result captured; job_abort in other states is ignored; job_start wins over a same-cycle job_abort.
REQ-017 success_in and round_done_in outside RUN SHALL be ignored.
REQ-018 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-019 While reset=1, the block SHALL enter IDLE with core_reset_n=0, ready=0, busy=0, exhausted=0, result_nonce=0, result_flags=0, and all counters at 0; reset has priority over every input.
REQ-020 Reset asserted mid-job SHALL discard the job with no result; the first cycle after reset deasserts is IDLE.

Configuration
REQ-021 Macro JOB_SEQUENCER_EXHAUST_EN: when defined, the round counter, REQ-010 and DONE_EMPTY are compiled in.
REQ-022 When JOB_SEQUENCER_EXHAUST_EN is not defined, RUN ends only on success_in, job_abort or job_start; exhausted is tied to 0 and round_done_in is unused.

Verification
REQ-023 Setup: RESET_HOLD=4, POOL_SIZE=2.
- Basic job: job_start -> core_reset_n stays 0 for exactly 4 cycles, then 1.
- Success: success_in with nonce_in=0x1234ABCD, match_flags_in=2'b10 -> result_nonce=0x1234ABCD, result_flags=2'b10, ready=1 and core_reset_n=0 one cycle later.
- Ack: result_ack -> IDLE, ready=0, result_nonce still 0x1234ABCD.
REQ-024 Exhaustion, with EXHAUST_LOG2=3 and the macro defined: 8 round_done_in pulses in RUN -> exhausted=1, ready=1.
- Same setup, success_in on the 8th pulse -> FOUND, exhausted=0.
REQ-025 Restart: job_start during RUN -> LOAD, counters and result cleared.
- job_abort in RUN -> IDLE, ready=0.
- Simultaneous job_start and job_abort -> LOAD.
REQ-026 Reset: reset pulsed in RUN and in FOUND -> next cycle IDLE, all outputs at reset values.
- Without the macro: 100 round_done_in pulses -> remains RUN, exhausted=0.
